// File: rtl/fft_ctrl_if.sv
// Handshake, memory-port and status bundle of the FFT sequencer.
// ctrl is the controller side; env is the surrounding datapath / stimulus side.
interface fft_ctrl_if #(
  parameter int AW = 6
) ();
  localparam int SW = $clog2(AW) + 1;

  logic          start_i;
  logic          abort_i;
  logic          sample_valid_i;
  logic          sample_ready_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_waddr_o;
  logic [AW-1:0] mem_raddr_o;
  logic          op_sel_o;
  logic          bfly_en_o;
  logic [AW-2:0] tw_idx_o;
  logic [SW-1:0] stage_o;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    state_o;

  modport ctrl (
    input  start_i, abort_i, sample_valid_i,
    output sample_ready_o, mem_we_o, mem_waddr_o, mem_raddr_o, op_sel_o,
           bfly_en_o, tw_idx_o, stage_o, busy_o, done_o, state_o
  );

  modport env (
    output start_i, abort_i, sample_valid_i,
    input  sample_ready_o, mem_we_o, mem_waddr_o, mem_raddr_o, op_sel_o,
           bfly_en_o, tw_idx_o, stage_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 FFT sequencer: sample load, then AW stages of N_POINTS/2 butterflies.
// Optional FFT_CTRL_BITREV_EN: bit-reversed write addresses while loading samples.
module fft_ctrl #(
  parameter int N_POINTS = 64,
  parameter int BFLY_LAT = 2,
  parameter int AW       = $clog2(N_POINTS)
) (
  input  logic clk_i,
  input  logic rst_ni,
  fft_ctrl_if.ctrl bus
);
  localparam int SW   = $clog2(AW) + 1;
  localparam int LW   = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam int HALF = N_POINTS / 2;

  // Handshake: a sample is accepted in any cycle where sample_valid_i and
  // sample_ready_o are both high; ready is high for the whole LOAD state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    READ_A  = 3'd2,
    READ_B  = 3'd3,
    COMPUTE = 3'd4,
    WRITE_A = 3'd5,
    WRITE_B = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t        state, nxt;
  logic [AW-1:0] smp, smp_n;
  logic [SW-1:0] s, s_n;
  logic [AW-2:0] b, b_n;
  logic [LW-1:0] lat, lat_n;

  logic          ready_q, we_q, op_q, en_q, busy_q, done_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [AW-2:0] tw_q;
  logic [SW-1:0] stage_q;

  logic [AW-1:0] span_n, pos_n, addr_a_n, addr_b_n, tw_full_n;

  function automatic logic [AW-1:0] load_addr(input logic [AW-1:0] k);
    logic [AW-1:0] r;
`ifdef FFT_CTRL_BITREV_EN
    for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
`else
    r = k;
`endif
    return r;
  endfunction

  always_comb begin
    nxt   = state;
    smp_n = smp;
    s_n   = s;
    b_n   = b;
    lat_n = lat;
    if (bus.abort_i) begin
      nxt   = IDLE;
      smp_n = '0;
      s_n   = '0;
      b_n   = '0;
      lat_n = '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          nxt   = LOAD;
          smp_n = '0;
          s_n   = '0;
          b_n   = '0;
        end
        LOAD: if (bus.sample_valid_i) begin
          smp_n = smp + 1'b1;
          if (smp == AW'(N_POINTS - 1)) nxt = READ_A;
        end
        READ_A: nxt = READ_B;
        READ_B: begin
          nxt   = COMPUTE;
          lat_n = '0;
        end
        COMPUTE: begin
          if (lat == LW'(BFLY_LAT - 1)) nxt = WRITE_A;
          else lat_n = lat + 1'b1;
        end
        WRITE_A: nxt = WRITE_B;
        WRITE_B: begin
          if (b != (AW-1)'(HALF - 1)) begin
            b_n = b + 1'b1;
            nxt = READ_A;
          end else if (s != SW'(AW - 1)) begin
            b_n = '0;
            s_n = s + 1'b1;
            nxt = READ_A;
          end else begin
            nxt = DONE;
          end
        end
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Butterfly addressing for the butterfly/stage about to be entered, so the
  // registered outputs are already correct in the first cycle of each state.
  always_comb begin
    span_n    = AW'(1) << s_n;
    pos_n     = {1'b0, b_n} & (span_n - 1'b1);
    addr_a_n  = (({1'b0, b_n} >> s_n) << (s_n + 1'b1)) | pos_n;
    addr_b_n  = addr_a_n + span_n;
    tw_full_n = pos_n << (AW - 1 - s_n);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      smp     <= '0;
      s       <= '0;
      b       <= '0;
      lat     <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      op_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      tw_q    <= '0;
      stage_q <= '0;
    end else begin
      state   <= nxt;
      smp     <= smp_n;
      s       <= s_n;
      b       <= b_n;
      lat     <= lat_n;
      ready_q <= (nxt == LOAD);
      we_q    <= (nxt == WRITE_A) || (nxt == WRITE_B);
      op_q    <= (nxt == READ_B) || (nxt == WRITE_B);
      en_q    <= (nxt == COMPUTE);
      busy_q  <= (nxt != IDLE);
      done_q  <= (nxt == DONE);
      waddr_q <= '0;
      raddr_q <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      case (nxt)
        READ_A:  begin raddr_q <= addr_a_n; stage_q <= s_n; end
        READ_B:  begin raddr_q <= addr_b_n; stage_q <= s_n; end
        COMPUTE: begin tw_q <= tw_full_n[AW-2:0]; stage_q <= s_n; end
        WRITE_A: begin waddr_q <= addr_a_n; stage_q <= s_n; end
        WRITE_B: begin waddr_q <= addr_b_n; stage_q <= s_n; end
        default: ;
      endcase
    end
  end

  // Sample writes must land in the acceptance cycle, so only the valid
  // qualification is combinational; ready and the sample counter are registers.
  assign bus.sample_ready_o = ready_q;
  assign bus.mem_we_o       = we_q | (ready_q & bus.sample_valid_i);
  assign bus.mem_waddr_o    = ready_q ? load_addr(smp) : waddr_q;
  assign bus.mem_raddr_o    = raddr_q;
  assign bus.op_sel_o       = op_q;
  assign bus.bfly_en_o      = en_q;
  assign bus.tw_idx_o       = tw_q;
  assign bus.stage_o        = stage_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.state_o        = state;
endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl at N_POINTS=8, BFLY_LAT=2: load, full transform schedule, abort, async reset.
// Expected schedule is generated from stage/butterfly loops with plain arithmetic.
module tb_fft_ctrl;
  localparam int N   = 8;
  localparam int LAT = 2;
  localparam int AW  = 3;

  typedef struct {
    logic [2:0] st;
    logic       we;
    logic [2:0] wa;
    logic [2:0] ra;
    logic       op;
    logic       en;
    logic [1:0] tw;
    logic [2:0] stg;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  rec_t exp_q[$];

  fft_ctrl_if #(.AW(AW)) bus ();

  fft_ctrl #(.N_POINTS(N), .BFLY_LAT(LAT)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_load_addr(input int k);
    logic [2:0] v, r;
    v = 3'(k);
`ifdef FFT_CTRL_BITREV_EN
    r = {v[0], v[1], v[2]};
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.state_o), 0);
    chk({tag, "_busy"},  32'(bus.busy_o), 0);
    chk({tag, "_done"},  32'(bus.done_o), 0);
    chk({tag, "_ready"}, 32'(bus.sample_ready_o), 0);
    chk({tag, "_we"},    32'(bus.mem_we_o), 0);
    chk({tag, "_waddr"}, 32'(bus.mem_waddr_o), 0);
    chk({tag, "_raddr"}, 32'(bus.mem_raddr_o), 0);
    chk({tag, "_op"},    32'(bus.op_sel_o), 0);
    chk({tag, "_en"},    32'(bus.bfly_en_o), 0);
    chk({tag, "_tw"},    32'(bus.tw_idx_o), 0);
    chk({tag, "_stage"}, 32'(bus.stage_o), 0);
  endtask

  // Full transform schedule: every stage, every butterfly, 4+LAT cycles each.
  task automatic build_schedule();
    int span, pos, a, bb, tw;
    exp_q.delete();
    for (int s = 0; s < AW; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        span = 1 << s;
        pos  = b % span;
        a    = (b / span) * 2 * span + pos;
        bb   = a + span;
        tw   = (pos << (AW - 1 - s)) % (N / 2);
        exp_q.push_back('{3'd2, 1'b0, 3'd0, 3'(a), 1'b0, 1'b0, 2'd0, 3'(s)});
        exp_q.push_back('{3'd3, 1'b0, 3'd0, 3'(bb), 1'b1, 1'b0, 2'd0, 3'(s)});
        for (int l = 0; l < LAT; l++)
          exp_q.push_back('{3'd4, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 2'(tw), 3'(s)});
        exp_q.push_back('{3'd5, 1'b1, 3'(a), 3'd0, 1'b0, 1'b0, 2'd0, 3'(s)});
        exp_q.push_back('{3'd6, 1'b1, 3'(bb), 3'd0, 1'b1, 1'b0, 2'd0, 3'(s)});
      end
    end
  endtask

  task automatic start_load();
    tick();
    bus.start_i = 1'b1;
    bus.sample_valid_i = 1'b0;
    @(negedge clk);
    chk("idle_before_start", 32'(bus.state_o), 0);
    tick();
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("load_state", 32'(bus.state_o), 1);
    chk("load_ready", 32'(bus.sample_ready_o), 1);
    chk("load_busy",  32'(bus.busy_o), 1);
    chk("load_gap_we", 32'(bus.mem_we_o), 0);
  endtask

  task automatic load_samples(input bit gappy);
    int k = 0;
    int cyc = 0;
    logic v;
    while (k < N && cyc < 200) begin
      tick();
      if (!gappy) v = 1'b1;
      else if (cyc < 4) v = (cyc % 2 == 0);
      else v = 1'($urandom_range(0, 1));
      bus.sample_valid_i = v;
      bus.start_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("load_stay", 32'(bus.state_o), 1);
      chk("load_we", 32'(bus.mem_we_o), 32'(v));
      if (v) begin
        chk("load_waddr", 32'(bus.mem_waddr_o), 32'(exp_load_addr(k)));
        k++;
      end
      cyc++;
    end
    chk("load_complete", 32'(k), N);
    bus.start_i = 1'b0;
  endtask

  task automatic run_records(input int n, input int abort_at);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      tick();
      r = exp_q.pop_front();
      bus.start_i = 1'($urandom_range(0, 1));
      bus.sample_valid_i = 1'($urandom_range(0, 1));
      bus.abort_i = (i == abort_at);
      if (i == abort_at) bus.start_i = 1'b1;
      @(negedge clk);
      chk("sch_state", 32'(bus.state_o), 32'(r.st));
      chk("sch_we",    32'(bus.mem_we_o), 32'(r.we));
      chk("sch_waddr", 32'(bus.mem_waddr_o), 32'(r.wa));
      chk("sch_raddr", 32'(bus.mem_raddr_o), 32'(r.ra));
      chk("sch_op",    32'(bus.op_sel_o), 32'(r.op));
      chk("sch_en",    32'(bus.bfly_en_o), 32'(r.en));
      chk("sch_tw",    32'(bus.tw_idx_o), 32'(r.tw));
      chk("sch_stage", 32'(bus.stage_o), 32'(r.stg));
      chk("sch_busy",  32'(bus.busy_o), 1);
      chk("sch_done",  32'(bus.done_o), 0);
      chk("sch_ready", 32'(bus.sample_ready_o), 0);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.sample_valid_i = 1'b0;
    #3;
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_zero("idle");

    // Full run with gappy load, random start/valid noise during compute.
    start_load();
    load_samples(1'b1);
    build_schedule();
    chk("sched_len", 32'(exp_q.size()), AW * (N / 2) * (4 + LAT));
    run_records(exp_q.size(), -1);
    tick();
    bus.start_i = 1'b0;
    bus.sample_valid_i = 1'b0;
    @(negedge clk);
    chk("done_state", 32'(bus.state_o), 7);
    chk("done_pulse", 32'(bus.done_o), 1);
    chk("done_busy",  32'(bus.busy_o), 1);
    tick();
    @(negedge clk);
    check_zero("after_done");

    // Abort in the first COMPUTE cycle of stage 1, with start held high too.
    start_load();
    load_samples(1'b0);
    build_schedule();
    run_records(2 * (4 + LAT) * (N / 2) / 2 + 2 + 1, (4 + LAT) * (N / 2) + 2);
    tick();
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check_zero("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done_o), 0);
      chk("abort_idle", 32'(bus.state_o), 0);
    end

    // Restart after abort: counters start from zero; then reset during WRITE_B.
    start_load();
    load_samples(1'b0);
    build_schedule();
    run_records(4 + LAT, -1);
    #1 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    tick();
    rst_n = 1'b1;
    bus.start_i = 1'b0;
    tick();
    @(negedge clk);
    check_zero("post_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
